modmul_interleaved: RTL and testbench
=====================================

Name: modmul_interleaved

Overview:
- Sequential interleaved (double-and-add) modular multiplier: R = (A*B) mod P for the ECPA datapath, one multiplier bit per two cycles.
- Sits directly downstream of the prime-field operand registers and beside the Brent-Kung modular adder; the field ops scheduler drives it with the same start/done pulse protocol as the adder.
- Each step uses a conditional-subtract modular addition on WIDTH+1-bit sums.

Parameters:
- WIDTH, 256, operand/modulus width in bits; the bench also runs WIDTH=8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- A  input  WIDTH  multiplicand; precondition A < P.
- B  input  WIDTH  multiplier; any value.
- P  input  WIDTH  modulus; precondition P odd. P = 0 is handled as a special case.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done_mul  output  1  one-cycle pulse; R is valid in that cycle.
- R  output  WIDTH  result register; holds its value until the next DONE entry.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, a_q, b_q, p_q, idx, R = 0; busy=0; done_mul=0.
  - Reset mid-operation aborts immediately. No done_mul is produced for the aborted request.
- States: IDLE, DBL, ADD, DONE.
  - done_mul = (state==DONE).
  - busy = (state != IDLE).
- IDLE:
  - On the edge sampling start=1, latch a_q=A, b_q=B, p_q=P, acc=0, idx=WIDTH-1.
  - If P==0, go to DONE and load R=0. Otherwise go to DBL.
  - start=0 keeps the block in IDLE.
- DBL: acc <= modadd(acc, acc, p_q); go to ADD.
- ADD:
  - If b_q[idx], acc <= modadd(acc, a_q, p_q); otherwise acc is unchanged.
  - If idx==0: load R with the value acc takes on this edge, then go to DONE.
  - Otherwise: idx <= idx-1, go to DBL.
- DONE: lasts exactly one cycle, then goes to IDLE. A start seen in DONE is ignored.
- modadd(x, y, p):
  - s = {1'b0,x} + {1'b0,y} (WIDTH+1 bits).
  - Result = s - p if s >= p, else s[WIDTH-1:0].
  - Correct for x, y < p. Results for A >= P are undefined, but latency is unchanged and the block never hangs.
- Latency:
  - Start sampled at edge 0. DONE is entered at edge 2*WIDTH, so done_mul is high in the cycle after edge 2*WIDTH.
  - Latency is fixed and independent of B. The P==0 path enters DONE at edge 0.
- start while busy (DBL/ADD/DONE) is ignored. Inputs A/B/P may change freely after acceptance.
- Back-to-back: a start in the first IDLE cycle after DONE is accepted. The minimum request spacing is 2*WIDTH+2 cycles.
- idx is $clog2(WIDTH) bits. idx wrap below 0 never occurs because the idx==0 exit takes priority.

Decomposition:
- Shared package ecpa_pkg:
  - FIELD_WIDTH=256 constant.
  - modmul_state_t enum {IDLE, DBL, ADD, DONE}.
  - Optional SECP256K1_P constant for benches.
- One sub-module: modmul_add_step, a combinational modadd of width WIDTH.
  - Instantiated once; its second operand is muxed: acc in DBL, a_q in ADD.
  - This keeps the critical path to one WIDTH+1 add plus one WIDTH+1 compare/subtract.

Test Plan:
- WIDTH=256, A=5, B=3, P=7 -> R=1; done_mul high exactly in the cycle after edge 512; busy=1 during cycles 1..512.
- A=2, B=3, P=7, then an immediate restart A=6, B=6, P=7 on the first IDLE cycle -> R=6, then R=1; both accepted, and R holds 6 until the second DONE.
- P=secp256k1 prime, A=B=P-1 -> R=1; B=0 -> R=0 with the same 512-edge latency.
- P=0, A=B=1 -> done_mul in the cycle after edge 0, R=0; no DBL/ADD states visited.
- start pulsed at edge 100 during a busy operation (A=5, B=3, P=7) -> ignored; single done_mul, R=1.
- rst_n low at edge 200 of an operation -> R=0, busy=0, done_mul=0 immediately (async); no done_mul afterwards; next start computes normally.

Source files
------------

// File: rtl/ecpa_pkg.sv
// Shared ECPA field-arithmetic definitions: field width, the multiplier
// FSM state type and the secp256k1 prime.
package ecpa_pkg;

  localparam int unsigned FIELD_WIDTH = 256;

  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    IDLE,
    DBL,
    ADD,
    DONE
  } modmul_state_t;

endpackage

// File: rtl/modmul_add_step.sv
// Combinational modular addition: (x + y) mod p for x, y < p, computed on a
// WIDTH+1-bit sum with a single conditional subtract.
module modmul_add_step #(
  parameter int unsigned WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] d;

  always_comb begin
    s   = {1'b0, x} + {1'b0, y};
    d   = s - {1'b0, p};
    sum = (s >= {1'b0, p}) ? d[WIDTH-1:0] : s[WIDTH-1:0];
  end

endmodule

// File: rtl/modmul_interleaved.sv
// Interleaved (double-and-add) modular multiplier R = A*B mod P, scanning B
// MSB-first with one multiplier bit per DBL/ADD cycle pair.
module modmul_interleaved
  import ecpa_pkg::*;
#(
  parameter int unsigned WIDTH = FIELD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done_mul,
  output logic [WIDTH-1:0] R
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  modmul_state_t  state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] step_y;
  logic [WIDTH-1:0] step_sum;

  // One shared adder: doubling in DBL, adding the multiplicand in ADD.
  assign step_y = (state_q == DBL) ? acc_q : a_q;

  modmul_add_step #(.WIDTH(WIDTH)) u_add_step (
    .x   (acc_q),
    .y   (step_y),
    .p   (p_q),
    .sum (step_sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    idx_d   = idx_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = A;
          b_d   = B;
          p_d   = P;
          acc_d = '0;
          idx_d = IW'(WIDTH - 1);
          if (P == '0) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            state_d = DBL;
          end
        end
      end
      DBL: begin
        acc_d   = step_sum;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[idx_q]) acc_d = step_sum;
        if (idx_q == '0) begin
          r_d     = acc_d;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = DBL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done_mul = (state_q == DONE);
  assign R        = r_q;

endmodule

// File: tb/tb_modmul_interleaved.sv
// Scoreboard bench for modmul_interleaved at WIDTH=256 and WIDTH=8: requests
// push expected result and done cycle, monitors pop on every done_mul.
module tb_modmul_interleaved;
  import ecpa_pkg::*;

  localparam int unsigned W  = 256;
  localparam int unsigned W8 = 8;

  typedef struct {
    logic [255:0] r;
    int unsigned  cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_fail;

  logic         start;
  logic [W-1:0] a_in, b_in, p_in;
  logic         busy, done_mul;
  logic [W-1:0] r_out;

  logic          start8;
  logic [W8-1:0] a8, b8, p8;
  logic          busy8, done8;
  logic [W8-1:0] r8;

  exp_t q256[$];
  exp_t q8[$];
  exp_t e256, e8;

  modmul_interleaved #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in), .P(p_in),
    .busy(busy), .done_mul(done_mul), .R(r_out)
  );

  modmul_interleaved #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .P(p8),
    .busy(busy8), .done_mul(done8), .R(r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_mul) begin
      if (q256.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done256: done_mul with no request outstanding (cycle %0d)", cyc);
      end else begin
        e256 = q256.pop_front();
        chk("r256", r_out, e256.r);
        chk("lat256", 256'(cyc), 256'(e256.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done8: done_mul with no request outstanding (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("r8", 256'(r8), e8.r);
        chk("lat8", 256'(cyc), 256'(e8.cyc));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p,
                       input logic [W-1:0] exp_r, input bit push, output int unsigned acc);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    p_in  = p;
    start = 1'b1;
    acc   = cyc + 1;
    if (push) q256.push_back('{exp_r, (p == '0) ? acc : acc + 2 * W});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic [W8-1:0] p,
                        input logic [W8-1:0] exp_r);
    int unsigned acc;
    @(negedge clk);
    a8     = a;
    b8     = b;
    p8     = p;
    start8 = 1'b1;
    acc    = cyc + 1;
    q8.push_back('{256'(exp_r), (p == '0) ? acc : acc + 2 * W8});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned k;
    k = 0;
    while (!done_mul && k < 2 * W + 16) begin
      @(negedge clk);
      k++;
    end
    if (!done_mul) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no done_mul within %0d cycles", name, k);
    end
  endtask

  task automatic wait_done8(input string name);
    int unsigned k;
    k = 0;
    while (!done8 && k < 2 * W8 + 16) begin
      @(negedge clk);
      k++;
    end
    if (!done8) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no done_mul within %0d cycles", name, k);
    end
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  logic [W8-1:0] va8[7] = '{8'd200, 8'd100, 8'd250, 8'd0,  8'd3,   8'd12, 8'd1};
  logic [W8-1:0] vb8[7] = '{8'd150, 8'd255, 8'd250, 8'd77, 8'd255, 8'd12, 8'd1};
  logic [W8-1:0] vp8[7] = '{8'd251, 8'd251, 8'd251, 8'd13, 8'd13,  8'd13, 8'd0};
  logic [W8-1:0] vr8[7] = '{8'd131, 8'd149, 8'd1,   8'd0,  8'd11,  8'd1,  8'd0};

  initial begin
    int unsigned acc, acc2;
    logic [W-1:0] pm1;
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start8 = 1'b0;
    a_in = '0; b_in = '0; p_in = '0;
    a8 = '0; b8 = '0; p8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_r", r_out, '0);
    chk("reset_busy", 256'(busy), '0);
    chk("reset_done", 256'(done_mul), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue8(va8[i], vb8[i], vp8[i], vr8[i]);
      wait_done8("done8_vec");
    end

    issue(5, 3, 7, 1, 1'b1, acc);
    chk("busy_first", 256'(busy), 256'(1));
    wait_until(acc + 2 * W - 1);
    chk("busy_last_add", 256'(busy), 256'(1));
    chk("done_early", 256'(done_mul), '0);
    wait_done("done_basic");
    @(negedge clk);
    chk("busy_after_done", 256'(busy), '0);
    chk("done_pulse_width", 256'(done_mul), '0);

    issue(2, 3, 7, 6, 1'b1, acc);
    wait_done("done_b2b_first");
    issue(6, 6, 7, 1, 1'b1, acc2);
    chk("b2b_accepted", 256'(busy), 256'(1));
    wait_until(acc2 + 50);
    chk("r_holds", r_out, 256'd6);
    wait_done("done_b2b_second");

    pm1 = SECP256K1_P - 1;
    issue(pm1, '0, SECP256K1_P, '0, 1'b1, acc);
    wait_done("done_secp_b0");
    issue(pm1, pm1, SECP256K1_P, 256'd1, 1'b1, acc);
    wait_done("done_secp");

    issue(1, 1, '0, '0, 1'b1, acc);
    chk("p0_done", 256'(done_mul), 256'(1));
    @(negedge clk);
    chk("p0_no_dbl", 256'(busy), '0);

    issue(5, 3, 7, 1, 1'b1, acc);
    wait_until(acc + 99);
    a_in = 3; b_in = 3; p_in = 11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_busy_start");
    a_in = 3; b_in = 3; p_in = 11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W + 10) @(negedge clk);
    chk("idle_after_ignored", 256'(busy), '0);

    issue(5, 3, 7, 1, 1'b0, acc);
    wait_until(acc + 199);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_r", r_out, '0);
    chk("abort_busy", 256'(busy), '0);
    chk("abort_done", 256'(done_mul), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W + 10) @(negedge clk);
    issue(6, 6, 7, 1, 1'b1, acc);
    wait_done("done_after_abort");

    @(negedge clk);
    chk("queue256_empty", 256'(q256.size()), '0);
    chk("queue8_empty", 256'(q8.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
